// File: rtl/alu_result_stage.sv
// Result stage behind the 8-bit ALU: a 2-entry skid buffer toward register-file
// writeback, the architectural compare-flag register, and a bypass port for operand read.
module alu_result_stage #(
    parameter int W  = 8,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  alu_out,
    input  logic          alu_zero,
    input  logic          alu_less_than,
    input  logic          op_cmp,
    input  logic          wr_en_in,
    input  logic [RA-1:0] wr_addr_in,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [W-1:0]  wb_data,
    output logic [RA-1:0] wb_addr,
    output logic          wb_en,
    output logic          flag_zero,
    output logic          flag_lt,
    input  logic [RA-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [W-1:0]  fwd_data
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [RA-1:0] addr;
        logic          wr_en;
    } entry_t;

    state_t state, state_nxt;
    entry_t main_q, main_nxt;
    entry_t skid_q, skid_nxt;
    entry_t in_entry;
    logic   accept_any, accept, cmp_accept, retire;

    // Handshake decodes depend on the state register only, so wb_ready never reaches in_ready.
    assign in_ready = (state != TWO);
    assign wb_valid = (state != EMPTY);

    assign accept_any = in_valid & in_ready;
    assign accept     = accept_any & ~op_cmp;
    assign cmp_accept = accept_any & op_cmp;
    assign retire     = wb_valid & wb_ready;
    assign in_entry   = {alu_out, wr_addr_in, wr_en_in};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    main_nxt  = in_entry;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    main_nxt = in_entry;
                end else if (accept) begin
                    state_nxt = TWO;
                    skid_nxt  = in_entry;
                end else if (retire) begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                end
            end
            TWO: begin
                if (retire) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                    skid_nxt  = '0;
                end
            end
            default: begin
                state_nxt = EMPTY;
                main_nxt  = '0;
                skid_nxt  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            flag_zero <= 1'b0;
            flag_lt   <= 1'b0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
            if (cmp_accept) begin
                flag_zero <= alu_zero;
                flag_lt   <= alu_less_than;
            end
        end
    end

    assign wb_data = main_q.data;
    assign wb_addr = main_q.addr;
    assign wb_en   = main_q.wr_en;

    // Skid holds the younger entry, so it wins over main on an address match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (state == TWO && skid_q.wr_en && skid_q.addr == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = skid_q.data;
        end else if (state != EMPTY && main_q.wr_en && main_q.addr == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = main_q.data;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_result_stage;

    localparam int W  = 8;
    localparam int RA = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  alu_out;
    logic          alu_zero, alu_less_than, op_cmp, wr_en_in;
    logic [RA-1:0] wr_addr_in;
    logic          wb_valid, wb_ready, wb_en;
    logic [W-1:0]  wb_data;
    logic [RA-1:0] wb_addr;
    logic          flag_zero, flag_lt;
    logic [RA-1:0] fwd_addr;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;

    int checks   = 0;
    int failures = 0;

    alu_result_stage #(.W(W), .RA(RA)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_less_than(alu_less_than),
        .op_cmp(op_cmp), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en),
        .flag_zero(flag_zero), .flag_lt(flag_lt),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order FIFO of at most two writeback entries plus two flags.
    typedef struct {
        logic [W-1:0]  data;
        logic [RA-1:0] addr;
        logic          en;
    } ent_t;

    ent_t m_q[$];
    logic m_fz = 1'b0;
    logic m_flt = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_fz  = 1'b0;
            m_flt = 1'b0;
        end else begin
            automatic bit can_take = (m_q.size() < 2);
            automatic bit ret      = (m_q.size() > 0) && wb_ready;
            automatic bit take     = in_valid && can_take && !op_cmp;
            if (in_valid && can_take && op_cmp) begin
                m_fz  = alu_zero;
                m_flt = alu_less_than;
            end
            if (ret) void'(m_q.pop_front());
            if (take) m_q.push_back('{data: alu_out, addr: wr_addr_in, en: wr_en_in});
        end
    end

    always @(negedge clk) begin
        automatic logic          e_hit  = 1'b0;
        automatic logic [W-1:0]  e_fd   = '0;
        automatic bit            has    = (m_q.size() > 0);
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (!e_hit && m_q[i].en && m_q[i].addr == fwd_addr) begin
                e_hit = 1'b1;
                e_fd  = m_q[i].data;
            end
        end
        check("cyc_in_ready", in_ready, m_q.size() < 2);
        check("cyc_wb_valid", wb_valid, has);
        check("cyc_wb_data", wb_data, has ? m_q[0].data : '0);
        check("cyc_wb_addr", wb_addr, has ? m_q[0].addr : '0);
        check("cyc_wb_en", wb_en, has ? m_q[0].en : 1'b0);
        check("cyc_flag_zero", flag_zero, m_fz);
        check("cyc_flag_lt", flag_lt, m_flt);
        check("cyc_fwd_hit", fwd_hit, e_hit);
        check("cyc_fwd_data", fwd_data, e_fd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] d, input logic [RA-1:0] a, input logic en);
        in_valid   = 1'b1;
        op_cmp     = 1'b0;
        alu_out    = d;
        wr_addr_in = a;
        wr_en_in   = en;
    endtask

    task automatic cmp(input logic z, input logic lt);
        in_valid      = 1'b1;
        op_cmp        = 1'b1;
        alu_zero      = z;
        alu_less_than = lt;
        alu_out       = 8'hEE;
        wr_addr_in    = 4'd9;
        wr_en_in      = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op_cmp   = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_out = '0; alu_zero = 1'b0; alu_less_than = 1'b0;
        op_cmp = 1'b0; wr_en_in = 1'b0; wr_addr_in = '0; wb_ready = 1'b0; fwd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_data", wb_data, 0);
        check("rst_flags", {flag_zero, flag_lt}, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        rst_n = 1'b1;
        step();

        // Single accept with 1-cycle latency
        wb_ready = 1'b1; put(8'h3C, 4'd5, 1'b1);
        step(); idle();
        check("single_valid", wb_valid, 1);
        check("single_data", wb_data, 8'h3C);
        check("single_addr", wb_addr, 5);
        check("single_en", wb_en, 1);
        step();
        check("single_retired", wb_valid, 0);
        check("single_zeroed", wb_data, 0);

        // Backpressure fills both entries; a third offer is refused
        wb_ready = 1'b0; put(8'h11, 4'd1, 1'b1);
        step(); put(8'h22, 4'd2, 1'b1);
        step(); put(8'h33, 4'd3, 1'b1);
        check("bp_in_ready", in_ready, 0);
        check("bp_head_held", wb_data, 8'h11);
        step(); idle();
        check("bp_still_head", wb_data, 8'h11);
        check("bp_still_full", in_ready, 0);
        wb_ready = 1'b1;
        step();
        check("bp_second", wb_data, 8'h22);
        check("bp_second_addr", wb_addr, 2);
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_empty", wb_valid, 0);

        // Compare entries touch only the flags
        cmp(1'b1, 1'b0);
        step();
        check("cmp1_flags", {flag_zero, flag_lt}, 2'b10);
        check("cmp1_no_wb", wb_valid, 0);
        cmp(1'b0, 1'b1);
        step(); idle();
        check("cmp2_flags", {flag_zero, flag_lt}, 2'b01);
        check("cmp2_no_wb", wb_valid, 0);

        // Forward priority: skid beats main for the same register
        wb_ready = 1'b0; put(8'hAA, 4'd3, 1'b1);
        step(); put(8'h55, 4'd3, 1'b1);
        step(); idle();
        fwd_addr = 4'd3; #1;
        check("fwd_hit_young", fwd_hit, 1);
        check("fwd_data_young", fwd_data, 8'h55);
        fwd_addr = 4'd4; #1;
        check("fwd_miss_hit", fwd_hit, 0);
        check("fwd_miss_data", fwd_data, 0);
        fwd_addr = 4'd3;
        wb_ready = 1'b1;
        step();
        check("fwd_after_pop", fwd_data, 8'h55);
        step();
        check("fwd_empty", fwd_hit, 0);

        // Simultaneous retire and accept in ONE
        wb_ready = 1'b0; put(8'h01, 4'd1, 1'b1);
        step();
        wb_ready = 1'b1; put(8'h02, 4'd2, 1'b1);
        step(); idle(); wb_ready = 1'b0;
        check("swap_valid", wb_valid, 1);
        check("swap_data", wb_data, 8'h02);
        check("swap_addr", wb_addr, 2);
        check("swap_one", in_ready, 1);
        step();
        check("swap_hold", wb_data, 8'h02);
        wb_ready = 1'b1;
        step();
        check("swap_empty", wb_valid, 0);

        // Non-writing entry keeps order and is not forwarded; flags hold
        wb_ready = 1'b0; put(8'h77, 4'd6, 1'b0);
        step(); put(8'h88, 4'd6, 1'b1);
        step(); idle();
        fwd_addr = 4'd6; #1;
        check("nowr_fwd", fwd_data, 8'h88);
        check("nowr_head_en", wb_en, 0);
        check("nowr_head_data", wb_data, 8'h77);
        wb_ready = 1'b1;
        step();
        check("nowr_next", {wb_en, wb_data}, {1'b1, 8'h88});
        check("nowr_flags_hold", {flag_zero, flag_lt}, 2'b01);
        step();

        // Async reset while full with flags set
        cmp(1'b1, 1'b1);
        step();
        wb_ready = 1'b0; put(8'hC1, 4'd7, 1'b1);
        step(); put(8'hC2, 4'd7, 1'b1);
        step(); idle();
        fwd_addr = 4'd7;
        check("pre_rst_full", in_ready, 0);
        check("pre_rst_flags", {flag_zero, flag_lt}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wb_valid", wb_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_flags", {flag_zero, flag_lt}, 0);
        check("arst_fwd_hit", fwd_hit, 0);
        check("arst_wb_data", wb_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        wb_ready = 1'b1; put(8'h5A, 4'd7, 1'b1);
        step(); idle();
        check("post_rst_valid", wb_valid, 1);
        check("post_rst_data", wb_data, 8'h5A);
        step();
        check("post_rst_empty", wb_valid, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the combinational 8-bit ALU.
- Captures ALU result, destination register and compare flags into a 2-entry skid buffer with a valid/ready handshake toward register-file writeback.
- Holds the architectural flag register (zero, less_than) and provides a combinational forwarding port so the operand-read stage can bypass buffered results.

Parameters:
W, 8, data width (matches ALU width)
RA, 4, register address width (2^RA registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage can accept an entry
alu_out  input  W  ALU data output
alu_zero  input  1  ALU zero comparison output
alu_less_than  input  1  ALU less_than comparison output
op_cmp  input  1  entry is a compare: update flags only, no writeback
wr_en_in  input  1  entry writes a register
wr_addr_in  input  RA  destination register
wb_valid  output  1  head entry presented to writeback
wb_ready  input  1  writeback accepts head entry
wb_data  output  W  head entry data
wb_addr  output  RA  head entry destination
wb_en  output  1  head entry register-write enable
flag_zero  output  1  architectural zero flag
flag_lt  output  1  architectural less_than flag
fwd_addr  input  RA  register being read by operand stage
fwd_hit  output  1  a buffered entry targets fwd_addr
fwd_data  output  W  data of youngest matching entry

Behaviour:
- Reset (async, rst_n=0): state EMPTY; both entries invalid; wb_valid=0; wb_data=0; wb_addr=0; wb_en=0; flag_zero=0; flag_lt=0; in_ready=1; fwd_hit=0; fwd_data=0. Reset mid-transfer discards buffered entries without writeback.
- Storage: main (head) and skid registers, each holding {data, addr, wr_en}.
- Three states:
  - EMPTY: in_ready=1, wb_valid=0.
  - ONE: main valid; in_ready=1; wb_valid=1.
  - TWO: both valid; in_ready=0; wb_valid=1.
- in_ready is a registered function of state only, with no combinational path from wb_ready.
- Accept when in_valid & in_ready; retire when wb_valid & wb_ready.
- Compare entry (accepted with op_cmp=1):
  - next cycle flag_zero<=alu_zero and flag_lt<=alu_less_than.
  - Not buffered; state unchanged by it.
- Non-compare entry (op_cmp=0) is buffered; flags hold.
- Transitions, counting only non-compare accepts:
  - EMPTY + accept -> ONE: the entry is loaded into main, and wb_valid rises the next cycle (1-cycle latency).
  - ONE + accept, no retire -> TWO: the entry goes to skid.
  - ONE + retire + accept -> ONE: the new entry is loaded into main.
  - ONE + retire, no accept -> EMPTY.
  - TWO + retire -> ONE: skid moves to main, and skid is cleared.
  - TWO: no accept possible (in_ready=0).
- Entry with op_cmp=0, wr_en_in=0: buffered and retired normally with wb_en=0, preserving order.
- wb_* outputs are stable while wb_valid=1 and wb_ready=0.
- When invalid, the main register is zeroed, giving wb_data=0, wb_addr=0 and wb_en=0.
- Forwarding (combinational):
  - Candidates are valid entries with wr_en=1 and addr==fwd_addr.
  - Skid (younger) has priority over main.
  - fwd_hit=0 and fwd_data=0 when there is no candidate.
  - The in-flight input is not forwarded.
- Data is stored unmodified; no width conversion. The address compare is exact over RA bits.

Test Plan:
- Reset then single accept: alu_out=8'h3C, wr_addr_in=5, wb_ready=1 -> next cycle wb_valid=1, wb_data=3C, wb_addr=5, wb_en=1; following cycle wb_valid=0.
- Backpressure: wb_ready=0; accept A=8'h11 (r1), then B=8'h22 (r2) -> state TWO, in_ready=0, wb_data=11 held. Raise wb_ready -> 11 retires, then 22, then EMPTY, in_ready=1.
- Compare: accept op_cmp=1, alu_zero=1, alu_less_than=0 -> next cycle flag_zero=1, flag_lt=0, wb_valid stays 0. Second compare with zero=0, lt=1 -> flags 0,1.
- Forward priority: buffer r3=8'hAA (main), then r3=8'h55 (skid), wb_ready=0, fwd_addr=3 -> fwd_hit=1, fwd_data=55. fwd_addr=4 -> fwd_hit=0, fwd_data=0.
- Simultaneous retire+accept in ONE: main=8'h01 (r1), wb_ready=1, accept 8'h02 (r2) -> next cycle main=02 (r2), state ONE, no entry lost or duplicated.
- Async reset in TWO with flags set: drop rst_n mid-cycle -> immediately wb_valid=0, in_ready=1, flags=0, fwd_hit=0; after release, first accept behaves as from EMPTY.
